hs_bus_amba_axilite_reg_bridge: RTL and testbench

AXI5-Lite subordinate that terminates one AXI-Lite port (the slave side of `hs_bus_amba_axilite_if`) and converts each transaction into a single request on a simple req/ack register bus for peripheral register files. It sits directly downstream of the AXI-Lite interface and upstream of the block's CSR logic. It handles one transaction at a time, with independent AW/W/AR holding registers, read/write arbitration, address decode errors and an ack timeout.

---
 rtl/hs_bus_amba_axilite_reg_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_hs_bus_amba_axilite_reg_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_bus_amba_axilite_reg_bridge.sv
// AXI-Lite subordinate that turns each AW+W or AR transaction into one req/ack register access.
// One transaction in flight at a time; round-robin read/write grant, decode errors, ack timeout.
module hs_bus_amba_axilite_reg_bridge #(
  parameter int unsigned ID_W_WIDTH     = 1,
  parameter int unsigned ID_R_WIDTH     = 1,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned REG_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ID_W_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [STRB_WIDTH-1:0]     wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [ID_W_WIDTH-1:0]     bid,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ID_R_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ID_R_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [STRB_WIDTH-1:0]     reg_wstrb,
  input  logic                      reg_ack,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_err
);

  localparam int unsigned AlignW = $clog2(STRB_WIDTH);
  localparam int unsigned CntW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [2:0] {StIdle, StWrReq, StRdReq, StWrResp, StRdResp} state_e;

  state_e                  state_q;
  logic                    rst_done_q;
  logic                    aw_full_q, w_full_q, ar_full_q;
  logic [ID_W_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [2:0]              aw_prot_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic [ID_R_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [2:0]              ar_prot_q;
  logic                    last_wr_q;
  logic [CntW-1:0]         cnt_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    wr_elig, rd_elig, grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic                    dec_err, align_err, any_err;
  logic                    timeout, req_done, clr_wr, clr_rd;
  logic                    unused_prot;

  assign awready = !aw_full_q && rst_done_q;
  assign wready  = !w_full_q && rst_done_q;
  assign arready = !ar_full_q && rst_done_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Protection bits are held for visibility only; they do not take part in decode.
  assign unused_prot = ^{aw_prot_q, ar_prot_q};

  assign wr_elig  = aw_full_q && w_full_q;
  assign rd_elig  = ar_full_q;
  assign grant_wr = (state_q == StIdle) && wr_elig && (!rd_elig || !last_wr_q);
  assign grant_rd = (state_q == StIdle) && rd_elig && !grant_wr;

  assign gnt_addr  = grant_wr ? aw_addr_q : ar_addr_q;
  assign dec_err   = (gnt_addr >> REG_ADDR_WIDTH) != '0;
  assign align_err = gnt_addr[AlignW-1:0] != '0;
  assign any_err   = dec_err || align_err;

  assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign req_done = reg_ack || timeout;

  assign clr_wr = (grant_wr && any_err) || ((state_q == StWrReq) && req_done);
  assign clr_rd = (grant_rd && any_err) || ((state_q == StRdReq) && req_done);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_id_q   <= awid;
        aw_addr_q <= awaddr;
        aw_prot_q <= awprot;
      end else if (clr_wr) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (clr_wr) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_id_q   <= arid;
        ar_addr_q <= araddr;
        ar_prot_q <= arprot;
      end else if (clr_rd) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= RespOkay;
      rvalid    <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= RespOkay;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_wr || grant_rd) begin
            last_wr_q <= grant_wr;
            if (any_err) begin
              if (grant_wr) begin
                bvalid  <= 1'b1;
                bid     <= aw_id_q;
                bresp   <= dec_err ? RespDecErr : RespSlvErr;
                state_q <= StWrResp;
              end else begin
                rvalid  <= 1'b1;
                rid     <= ar_id_q;
                rresp   <= dec_err ? RespDecErr : RespSlvErr;
                rdata   <= '0;
                state_q <= StRdResp;
              end
            end else begin
              reg_req   <= 1'b1;
              reg_we    <= grant_wr;
              reg_addr  <= gnt_addr[REG_ADDR_WIDTH-1:0];
              reg_wdata <= grant_wr ? w_data_q : '0;
              reg_wstrb <= grant_wr ? w_strb_q : '0;
              cnt_q     <= '0;
              state_q   <= grant_wr ? StWrReq : StRdReq;
            end
          end
        end
        StWrReq, StRdReq: begin
          if (req_done) begin
            reg_req <= 1'b0;
            if (state_q == StWrReq) begin
              bvalid  <= 1'b1;
              bid     <= aw_id_q;
              bresp   <= (!reg_ack || reg_err) ? RespSlvErr : RespOkay;
              state_q <= StWrResp;
            end else begin
              rvalid  <= 1'b1;
              rid     <= ar_id_q;
              rresp   <= (!reg_ack || reg_err) ? RespSlvErr : RespOkay;
              // A timed-out read returns no data rather than whatever the bus happens to show.
              rdata   <= reg_ack ? reg_rdata : '0;
              state_q <= StRdResp;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWrResp: begin
          if (bready) begin
            bvalid  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRdResp: begin
          if (rready) begin
            rvalid  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_bus_amba_axilite_reg_bridge.sv
// Directed bench for the AXI-Lite to register-bus bridge, ack timeout set to 8 cycles.
module tb_hs_bus_amba_axilite_reg_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        awvalid, awready;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        reg_req, reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_err;

  int n_checks = 0;
  int n_err    = 0;
  int hi;
  int bv_at;

  always #5 aclk = ~aclk;

  hs_bus_amba_axilite_reg_bridge #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .araddr    (araddr),
    .arprot    (arprot),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .reg_err   (reg_err)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awvalid = 1'b0; awid = '0; awaddr = '0; awprot = 3'b000;
    wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; arid = '0; araddr = '0; arprot = 3'b000; rready = 1'b0;
    reg_ack = 1'b1; reg_rdata = '0; reg_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_awready", 64'(awready), 0);
    chk("rst_wready", 64'(wready), 0);
    chk("rst_arready", 64'(arready), 0);
    chk("rst_bvalid", 64'(bvalid), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_reg_req", 64'(reg_req), 0);
    chk("rst_rdata", 64'(rdata), 0);
    aresetn = 1'b1;
    chk("rel_awready_low", 64'(awready), 0);
    tick();
    chk("rel_awready", 64'(awready), 1);
    chk("rel_wready", 64'(wready), 1);
    chk("rel_arready", 64'(arready), 1);

    // Basic write, ack immediate
    awvalid = 1'b1; awaddr = 32'h0000_0010; awid = 1'b1; awprot = 3'b010;
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr1_c1_awready", 64'(awready), 0);
    chk("wr1_c1_req", 64'(reg_req), 0);
    tick();
    chk("wr1_c2_req", 64'(reg_req), 1);
    chk("wr1_c2_we", 64'(reg_we), 1);
    chk("wr1_c2_addr", 64'(reg_addr), 64'h010);
    chk("wr1_c2_wdata", 64'(reg_wdata), 64'hDEAD_BEEF);
    chk("wr1_c2_wstrb", 64'(reg_wstrb), 64'hF);
    tick();
    chk("wr1_c3_bvalid", 64'(bvalid), 1);
    chk("wr1_c3_bresp", 64'(bresp), 0);
    chk("wr1_c3_bid", 64'(bid), 1);
    chk("wr1_c3_req", 64'(reg_req), 0);
    chk("wr1_c3_awready", 64'(awready), 1);
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("wr1_c4_bvalid", 64'(bvalid), 0);

    // W leads AW by 4 cycles
    wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
    tick();
    wvalid = 1'b0;
    chk("wlead_wready_held", 64'(wready), 0);
    tick(); tick(); tick();
    chk("wlead_req_none", 64'(reg_req), 0);
    awvalid = 1'b1; awaddr = 32'h0000_0020; awid = 1'b0;
    tick();
    awvalid = 1'b0;
    chk("wlead_c5_req", 64'(reg_req), 0);
    tick();
    chk("wlead_c6_req", 64'(reg_req), 1);
    chk("wlead_c6_addr", 64'(reg_addr), 64'h020);
    chk("wlead_c6_wdata", 64'(reg_wdata), 64'hA5A5_A5A5);
    chk("wlead_c6_wstrb", 64'(reg_wstrb), 64'h3);
    tick();
    chk("wlead_bvalid", 64'(bvalid), 1);
    chk("wlead_bid", 64'(bid), 0);
    tick();

    // Read 0x10
    reg_rdata = 32'h1234_5678;
    arvalid = 1'b1; araddr = 32'h0000_0010; arid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    chk("rd_c2_req", 64'(reg_req), 1);
    chk("rd_c2_we", 64'(reg_we), 0);
    chk("rd_c2_addr", 64'(reg_addr), 64'h010);
    tick();
    chk("rd_c3_rvalid", 64'(rvalid), 1);
    chk("rd_c3_rdata", 64'(rdata), 64'h1234_5678);
    chk("rd_c3_rresp", 64'(rresp), 0);
    chk("rd_c3_rid", 64'(rid), 1);
    tick();
    chk("rd_c4_rvalid", 64'(rvalid), 0);

    // Round-robin: write and read eligible together, twice
    reg_rdata = 32'hCAFE_F00D;
    awvalid = 1'b1; awaddr = 32'h0000_0040; awid = 1'b0;
    wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0000_0030; arid = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk("rr1_req", 64'(reg_req), 1);
    chk("rr1_we", 64'(reg_we), 1);
    chk("rr1_addr", 64'(reg_addr), 64'h040);
    tick();
    chk("rr1_bvalid", 64'(bvalid), 1);
    awvalid = 1'b1; awaddr = 32'h0000_0044; awid = 1'b1;
    wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hC;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("rr2_req", 64'(reg_req), 1);
    chk("rr2_we", 64'(reg_we), 0);
    chk("rr2_addr", 64'(reg_addr), 64'h030);
    tick();
    chk("rr2_rvalid", 64'(rvalid), 1);
    chk("rr2_rdata", 64'(rdata), 64'hCAFE_F00D);
    tick();
    chk("rr3_idle_req", 64'(reg_req), 0);
    tick();
    chk("rr3_req", 64'(reg_req), 1);
    chk("rr3_we", 64'(reg_we), 1);
    chk("rr3_addr", 64'(reg_addr), 64'h044);
    chk("rr3_wdata", 64'(reg_wdata), 64'h2222_2222);
    chk("rr3_wstrb", 64'(reg_wstrb), 64'hC);
    tick();
    chk("rr3_bvalid", 64'(bvalid), 1);
    chk("rr3_bid", 64'(bid), 1);
    tick();

    // Decode error on read
    arvalid = 1'b1; araddr = 32'h0001_0000; arid = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("decerr_c1_req", 64'(reg_req), 0);
    tick();
    chk("decerr_rvalid", 64'(rvalid), 1);
    chk("decerr_rresp", 64'(rresp), 64'h3);
    chk("decerr_rdata", 64'(rdata), 0);
    chk("decerr_c2_req", 64'(reg_req), 0);
    tick();

    // Unaligned write
    awvalid = 1'b1; awaddr = 32'h0000_0002; awid = 1'b1;
    wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("slverr_c1_req", 64'(reg_req), 0);
    tick();
    chk("slverr_bvalid", 64'(bvalid), 1);
    chk("slverr_bresp", 64'(bresp), 64'h2);
    chk("slverr_bid", 64'(bid), 1);
    chk("slverr_c2_req", 64'(reg_req), 0);
    tick();

    // Timeout with no ack, then stalled response
    reg_ack = 1'b0; bready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0000_0050; awid = 1'b1;
    wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF;
    hi = 0; bv_at = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
      if (reg_req) hi++;
      if (bvalid && bv_at < 0) bv_at = c;
    end
    chk("to_req_cycles", 64'(hi), 8);
    chk("to_bvalid_cycle", 64'(bv_at), 10);
    chk("to_bresp", 64'(bresp), 64'h2);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", 64'(bvalid), 1);
      chk("stall_bresp", 64'(bresp), 64'h2);
      chk("stall_bid", 64'(bid), 1);
      chk("stall_req", 64'(reg_req), 0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("to_bvalid_drop", 64'(bvalid), 0);

    // Reset in the middle of a register access
    awvalid = 1'b1; awaddr = 32'h0000_0060; awid = 1'b1;
    wvalid = 1'b1; wdata = 32'h9999_9999; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("mid_req", 64'(reg_req), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_req", 64'(reg_req), 0);
    chk("mid_rst_we", 64'(reg_we), 0);
    chk("mid_rst_addr", 64'(reg_addr), 0);
    chk("mid_rst_awready", 64'(awready), 0);
    chk("mid_rst_bvalid", 64'(bvalid), 0);
    tick();
    aresetn = 1'b1;
    reg_ack = 1'b1;
    chk("mid_rel_arready_low", 64'(arready), 0);
    tick();
    chk("mid_rel_awready", 64'(awready), 1);
    chk("mid_rel_arready", 64'(arready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_bvalid", 64'(bvalid), 0);
      chk("mid_no_req", 64'(reg_req), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
